mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM register and driving the MEM/WB-facing write-back outputs. Executes word loads and stores over a request/grant/response data bus, stalls the upstream pipeline while an access is outstanding, and registers the write-back result. It also provides a bus-timeout watchdog with a sticky fault flag.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in REQ+RESP before the access is abandoned (legal range 2–1023).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_result_in  in  32  effective address (memory ops) or ALU result (others)
- rs2_val_in  in  32  store data
- reg_write_in  in  1  instruction writes rd
- mem_read_in  in  1  load word
- mem_write_in  in  1  store word
- rd_idx_in  in  5  destination register
- stall_out  out  1  hold EX/MEM register and all earlier stages
- dbus_req  out  1  bus request, held until dbus_gnt
- dbus_we  out  1  1 = store, 0 = load
- dbus_addr  out  32  word address: captured address with bits [1:0] forced to 0
- dbus_wdata  out  32  captured store data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  load data valid
- dbus_rdata  in  32  load data
- wb_result_out  out  32  registered write-back value
- wb_reg_write_out  out  1  registered write enable
- wb_rd_idx_out  out  5  registered destination
- bus_fault_out  out  1  sticky timeout flag

## Operation
- States: IDLE, REQ, RESP, DONE (enum in package).
- IDLE, no memory op: on the edge, wb_result ← alu_result_in, wb_rd_idx ← rd_idx_in, wb_reg_write ← reg_write_in && rd_idx_in≠0; stall_out=0.
- IDLE, memory op (mem_read_in|mem_write_in): stall_out=1 combinationally; capture address, store data, rd, reg_write, and op type; wb_reg_write ← 0; go to REQ. If both read and write are set, the op is a store; no write-back.
- REQ: dbus_req=1 from captured registers; stall_out=1. On dbus_gnt: store → DONE; load → RESP.
- RESP: stall_out=1; dbus_req=0. On dbus_rvalid → DONE with wb_result ← dbus_rdata, wb_rd_idx ← captured rd, wb_reg_write ← captured reg_write && rd≠0.
- Store entering DONE: wb_reg_write ← 0.
- DONE: stall_out=0; inputs are ignored, since they still hold the completed instruction and upstream advances on this edge; wb_reg_write ← 0 unless overwritten by the new instruction; unconditional transition to IDLE.
- Watchdog: a counter clears on IDLE→REQ and increments each cycle in REQ/RESP. At TIMEOUT_CYCLES it sets bus_fault_out (sticky until reset), abandons the access (dbus_req drops), and enters DONE with wb_reg_write ← 0.
- dbus_rvalid outside RESP and dbus_gnt outside REQ are ignored.

## Timing
- Reset values: state IDLE, all wb_* 0, bus_fault_out 0, dbus_req 0, dbus_we 0, dbus_addr 0, dbus_wdata 0, counter 0. stall_out is 0 while reset is asserted.
- Non-memory op: wb outputs valid 1 cycle after the op appears at the inputs.
- Store with gnt in the first REQ cycle: stall for 2 cycles (IDLE, REQ), then DONE.
- Load with gnt and rvalid on consecutive cycles: stall for 3 cycles; wb outputs valid in the DONE cycle.
- Reset mid-access: dbus_req is 0 from the first cycle reset is sampled; the pending access is discarded; a late rvalid is ignored.

## Structure
- Package mem_access_pkg: state enum, word-address mask constant, default TIMEOUT_CYCLES.
- Sub-module: mem_bus_watchdog (clear, enable, expire, parameterized width $clog2(TIMEOUT_CYCLES+1)).

## Test plan
- ALU op alu_result_in=0x1234, rd=5, reg_write=1 → next cycle wb_result=0x1234, wb_rd=5, wb_reg_write=1, stall never high.
- Load addr 0x103, gnt in REQ cycle 1, rvalid+rdata=0xDEADBEEF 2 cycles later → dbus_addr=0x100, dbus_we=0, stall high 4 cycles, DONE cycle shows wb_result=0xDEADBEEF.
- Store addr 0x40, data 0xA5A5A5A5, gnt delayed 3 cycles → dbus_req held 4 cycles with stable addr/data, dbus_we=1, wb_reg_write=0 throughout.
- Load with rd=0 → bus access performed, wb_reg_write stays 0.
- TIMEOUT_CYCLES=4, no gnt → after 4 REQ cycles dbus_req drops, bus_fault_out=1 and stays 1 across later ops until reset.
- Reset asserted during RESP, then rvalid pulse → state IDLE, no write-back, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_access_pkg;

   localparam int unsigned XLEN                   = 32;
   localparam int unsigned REG_IDX_W              = 5;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

   localparam logic [XLEN-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   // Memory operation captured when it leaves the EX/MEM register.
   typedef struct packed {
      logic [XLEN-1:0]      addr;
      logic [XLEN-1:0]      wdata;
      logic [REG_IDX_W-1:0] rd;
      logic                 reg_write;
      logic                 is_store;
   } mem_op_t;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Cycle counter that flags an outstanding bus access as expired.
module mem_bus_watchdog
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_c_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Saturating count of cycles spent with an access outstanding.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires during the last permitted cycle so the FSM leaves on that edge.
   assign expire_c_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/gnt/rvalid bus with
// upstream stall, registered write-back and a sticky bus-timeout flag.
module mem_access_stage
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [XLEN-1:0]      alu_result_in,
   input  logic [XLEN-1:0]      rs2_val_in,
   input  logic                 reg_write_in,
   input  logic                 mem_read_in,
   input  logic                 mem_write_in,
   input  logic [REG_IDX_W-1:0] rd_idx_in,
   output logic                 stall_out,
   output logic                 dbus_req,
   output logic                 dbus_we,
   output logic [XLEN-1:0]      dbus_addr,
   output logic [XLEN-1:0]      dbus_wdata,
   input  logic                 dbus_gnt,
   input  logic                 dbus_rvalid,
   input  logic [XLEN-1:0]      dbus_rdata,
   output logic [XLEN-1:0]      wb_result_out,
   output logic                 wb_reg_write_out,
   output logic [REG_IDX_W-1:0] wb_rd_idx_out,
   output logic                 bus_fault_out
);

   mem_state_e           state_q, state_d;
   mem_op_t              op_q, op_d;
   logic [XLEN-1:0]      wb_result_q, wb_result_d;
   logic                 wb_reg_write_q, wb_reg_write_d;
   logic [REG_IDX_W-1:0] wb_rd_idx_q, wb_rd_idx_d;
   logic                 bus_fault_q, bus_fault_d;

   logic stall_c;
   logic wdog_clear_c;
   logic wdog_enable_c;
   logic wdog_expire_c;

   mem_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (wdog_clear_c),
      .enable_i   (wdog_enable_c),
      .expire_c_o (wdog_expire_c)
   );

   // Next-state, capture and write-back selection.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      wb_result_d    = wb_result_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_idx_d    = wb_rd_idx_q;
      bus_fault_d    = bus_fault_q;
      stall_c        = 1'b0;
      wdog_clear_c   = 1'b0;
      wdog_enable_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_read_in || mem_write_in) begin
               stall_c           = 1'b1;
               wdog_clear_c      = 1'b1;
               op_d.addr         = alu_result_in;
               op_d.wdata        = rs2_val_in;
               op_d.rd           = rd_idx_in;
               op_d.reg_write    = reg_write_in;
               op_d.is_store     = mem_write_in;
               wb_reg_write_d    = 1'b0;
               state_d           = ST_REQ;
            end else begin
               wb_result_d    = alu_result_in;
               wb_rd_idx_d    = rd_idx_in;
               wb_reg_write_d = reg_write_in && (rd_idx_in != '0);
            end
         end

         ST_REQ: begin
            stall_c       = 1'b1;
            wdog_enable_c = 1'b1;
            // A store granted in its last permitted cycle still completes.
            if (dbus_gnt && op_q.is_store) begin
               wb_reg_write_d = 1'b0;
               state_d        = ST_DONE;
            end else if (wdog_expire_c) begin
               bus_fault_d    = 1'b1;
               wb_reg_write_d = 1'b0;
               state_d        = ST_DONE;
            end else if (dbus_gnt) begin
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            stall_c       = 1'b1;
            wdog_enable_c = 1'b1;
            if (dbus_rvalid) begin
               wb_result_d    = dbus_rdata;
               wb_rd_idx_d    = op_q.rd;
               wb_reg_write_d = op_q.reg_write && (op_q.rd != '0);
               state_d        = ST_DONE;
            end else if (wdog_expire_c) begin
               bus_fault_d    = 1'b1;
               wb_reg_write_d = 1'b0;
               state_d        = ST_DONE;
            end
         end

         ST_DONE: begin
            wb_reg_write_d = 1'b0;
            state_d        = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         wb_result_q    <= '0;
         wb_reg_write_q <= 1'b0;
         wb_rd_idx_q    <= '0;
         bus_fault_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         wb_result_q    <= wb_result_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_idx_q    <= wb_rd_idx_d;
         bus_fault_q    <= bus_fault_d;
      end
   end

   assign stall_out        = stall_c && !reset;
   assign dbus_req         = (state_q == ST_REQ) && !reset;
   assign dbus_we          = op_q.is_store;
   assign dbus_addr        = op_q.addr & WORD_ADDR_MASK;
   assign dbus_wdata       = op_q.wdata;
   assign wb_result_out    = wb_result_q;
   assign wb_reg_write_out = wb_reg_write_q;
   assign wb_rd_idx_out    = wb_rd_idx_q;
   assign bus_fault_out    = bus_fault_q;

endmodule
